ws2812_multi_out: RTL and testbench

Parametrised N-channel parallel WS2812 output engine: it replaces the fixed eight per-layer output instances with one block that drives `CH_NUM` LED strings in lock-step. It sits after the SPI/layer control path on `sys_clk`. It reads one pixel word per channel per LED from an external frame buffer with a one-cycle read latency. It supports 24-bit (GRB) or 32-bit (GRBW) words, a runtime LED count, a per-channel enable mask, and queuing of one pending frame request.

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_bit_timer.sv | 46 ++++
 rtl/ws2812_multi_out.sv | 161 ++++++++++++++++
 tb/tb_ws2812_multi_out.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the parallel WS2812 output engine.
// Timing defaults assume an 80 MHz system clock.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_LATCH
  } state_t;

  localparam int DEF_BIT_CYC = 100;    // 1.25 us
  localparam int DEF_T0H_CYC = 32;     // 0.4 us
  localparam int DEF_T1H_CYC = 64;     // 0.8 us
  localparam int DEF_RST_CYC = 24000;  // 300 us

  localparam int WORD_GRB  = 24;
  localparam int WORD_GRBW = 32;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Shared bit-period and bit-index counters for all channels; decodes the
// bit boundaries and the two high-time windows from the current cycle count.
module ws2812_bit_timer #(
  parameter int BIT_CYC   = 100,
  parameter int WORD_BITS = 24,
  parameter int T0H_CYC   = 32,
  parameter int T1H_CYC   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic bit_first,
  output logic bit_last,
  output logic word_last,
  output logic hi_t0,
  output logic hi_t1
);

  localparam int CW = $clog2(BIT_CYC);
  localparam int BW = $clog2(WORD_BITS);

  logic [CW-1:0] cyc;
  logic [BW-1:0] bit_idx;

  assign bit_first = (cyc == '0);
  assign bit_last  = (cyc == CW'(BIT_CYC - 1));
  assign word_last = (bit_idx == BW'(WORD_BITS - 1));
  assign hi_t0     = (cyc < CW'(T0H_CYC));
  assign hi_t1     = (cyc < CW'(T1H_CYC));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc     <= '0;
      bit_idx <= '0;
    end else if (run) begin
      if (bit_last) begin
        cyc     <= '0;
        bit_idx <= word_last ? '0 : bit_idx + BW'(1);
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ws2812_multi_out.sv
// N-channel lock-step WS2812 serialiser: reads one word per channel per LED from
// a frame buffer (1-cycle read latency, data held until the next read) and shifts it out MSB first.
module ws2812_multi_out
  import ws2812_pkg::*;
#(
  parameter int CH_NUM    = 8,
  parameter int LED_NUM   = 64,
  parameter int WORD_BITS = WORD_GRB,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int RST_CYC   = DEF_RST_CYC,
  localparam int AW       = $clog2(LED_NUM)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_rdy_in,
  input  logic [AW:0]                   led_cnt_in,
  input  logic [CH_NUM-1:0]             ch_en_in,
  output logic                          rd_en_out,
  output logic [AW-1:0]                 rd_addr_out,
  input  logic [CH_NUM*WORD_BITS-1:0]   rd_data_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [CH_NUM-1:0]             ws2812_data_out
);

  localparam int LW = $clog2(RST_CYC + 1);
  localparam logic [AW:0] LED_MAX = LED_NUM[AW:0];

  if (!(T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
    $error("ws2812_multi_out: need T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if (WORD_BITS != WORD_GRB && WORD_BITS != WORD_GRBW) begin : g_bad_word
    $error("ws2812_multi_out: WORD_BITS must be 24 or 32");
  end

  state_t            state;
  logic [AW:0]       cnt_q;
  logic [CH_NUM-1:0] en_q;
  logic              pending;
  logic              nxt_vld;
  logic [LW-1:0]     lat_cnt;

  logic bit_first, bit_last, word_last, hi_t0, hi_t1;
  logic sending, lat_end, start, more, load_word, shift_bit;
  logic [AW:0] cnt_clamped;
  logic [AW:0] nxt_idx;

  assign sending     = (state == ST_SEND);
  assign lat_end     = (state == ST_LATCH) && (lat_cnt == LW'(RST_CYC));
  assign start       = ((state == ST_IDLE) && frame_rdy_in) || (lat_end && pending);
  assign cnt_clamped = (led_cnt_in > LED_MAX) ? LED_MAX : led_cnt_in;
  assign nxt_idx     = {1'b0, rd_addr_out} + {{AW{1'b0}}, 1'b1};
  assign more        = (nxt_idx < cnt_q);
  assign load_word   = (state == ST_LOAD) || (sending && bit_last && word_last && nxt_vld);
  assign shift_bit   = sending && bit_last && !word_last;

  ws2812_bit_timer #(
    .BIT_CYC  (BIT_CYC),
    .WORD_BITS(WORD_BITS),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_timer (
    .clk      (clk_in),
    .rst      (rst_in),
    .clr      (state == ST_LOAD),
    .run      (sending),
    .bit_first(bit_first),
    .bit_last (bit_last),
    .word_last(word_last),
    .hi_t0    (hi_t0),
    .hi_t1    (hi_t1)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      cnt_q       <= '0;
      en_q        <= '0;
      pending     <= 1'b0;
      nxt_vld     <= 1'b0;
      lat_cnt     <= '0;
      rd_en_out   <= 1'b0;
      rd_addr_out <= '0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      rd_en_out <= 1'b0;
      done_out  <= 1'b0;
      if (frame_rdy_in && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_IDLE:  ;
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD:  state <= ST_SEND;
        ST_SEND: begin
          if (bit_first && word_last && more) begin
            rd_en_out   <= 1'b1;
            rd_addr_out <= nxt_idx[AW-1:0];
            nxt_vld     <= 1'b1;
          end
          if (bit_last && word_last) begin
            if (nxt_vld) begin
              nxt_vld <= 1'b0;
            end else begin
              // Pins lag the counters by one clock, so the gap counts RST_CYC+1 states here.
              state   <= ST_LATCH;
              lat_cnt <= '0;
            end
          end
        end
        ST_LATCH: begin
          if (lat_end) begin
            done_out <= 1'b1;
            busy_out <= 1'b0;
            pending  <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (start) begin
        cnt_q    <= cnt_clamped;
        en_q     <= ch_en_in;
        busy_out <= 1'b1;
        if (cnt_clamped == '0) begin
          state   <= ST_LATCH;
          lat_cnt <= LW'(1);
        end else begin
          state       <= ST_FETCH;
          rd_en_out   <= 1'b1;
          rd_addr_out <= '0;
        end
      end
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [WORD_BITS-1:0] sh;
    logic                 q;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        sh <= '0;
        q  <= 1'b0;
      end else begin
        if (load_word) begin
          sh <= rd_data_in[c*WORD_BITS +: WORD_BITS];
        end else if (shift_bit) begin
          sh <= {sh[WORD_BITS-2:0], 1'b0};
        end
        q <= sending && en_q[c] && (sh[WORD_BITS-1] ? hi_t1 : hi_t0);
      end
    end

    assign ws2812_data_out[c] = q;
  end

endmodule

// File: tb/tb_ws2812_multi_out.sv
// Directed bench for ws2812_multi_out: 2 channels, 24-bit words, 10-clock bits.
module tb_ws2812_multi_out;

  localparam int NLOG = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_rdy = 1'b0;
  logic [2:0]  led_cnt = '0;
  logic [1:0]  ch_en = '0;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [47:0] rd_data = '0;
  logic        busy;
  logic        done;
  logic [1:0]  dout;

  logic [47:0] mem [0:3];

  logic [1:0] out_log  [0:NLOG-1];
  logic       rde_log  [0:NLOG-1];
  logic [1:0] addr_log [0:NLOG-1];
  logic       done_log [0:NLOG-1];
  logic       busy_log [0:NLOG-1];

  int total = 0;
  int bad   = 0;

  ws2812_multi_out #(
    .CH_NUM(2), .LED_NUM(4), .WORD_BITS(24), .BIT_CYC(10),
    .T0H_CYC(3), .T1H_CYC(6), .RST_CYC(20)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .frame_rdy_in   (frame_rdy),
    .led_cnt_in     (led_cnt),
    .ch_en_in       (ch_en),
    .rd_en_out      (rd_en),
    .rd_addr_out    (rd_addr),
    .rd_data_in     (rd_data),
    .busy_out       (busy),
    .done_out       (done),
    .ws2812_data_out(dout)
  );

  always #5 clk = ~clk;

  // Frame buffer: registered read, output held until the next read.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] cnt, input logic [1:0] en);
    @(negedge clk);
    frame_rdy = 1'b1;
    led_cnt   = cnt;
    ch_en     = en;
  endtask

  // Entry i is sampled after the i-th rising edge following the start edge.
  task automatic watch(input int n, input int p1, input int p2,
                       input logic [2:0] cnt2, input logic [1:0] en2);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_log[i]  = dout;
      rde_log[i]  = rd_en;
      addr_log[i] = rd_addr;
      done_log[i] = done;
      busy_log[i] = busy;
      frame_rdy   = (i == p1) || (i == p2);
      if (i == p1) begin
        led_cnt = cnt2;
        ch_en   = en2;
      end
    end
  endtask

  function automatic logic exp_bit(int ch, int t, int nled, logic en);
    int led, bitn, ph;
    logic [47:0] w;
    logic [23:0] v;
    if (!en || t < 0 || t >= nled * 240) return 1'b0;
    led  = t / 240;
    bitn = (t % 240) / 10;
    ph   = t % 10;
    w    = mem[led];
    v    = w[ch*24 +: 24];
    return (ph < (v[23-bitn] ? 6 : 3));
  endfunction

  function automatic int wave_err(int ch, int a, int b, int rise, int nled, logic en);
    int e = 0;
    for (int i = a; i <= b; i++)
      if (out_log[i][ch] !== exp_bit(ch, i - rise, nled, en)) e++;
    return e;
  endfunction

  function automatic int count_rd(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (rde_log[i]) n++;
    return n;
  endfunction

  function automatic int nth_addr(int a, int b, int k);
    int n = 0;
    for (int i = a; i <= b; i++)
      if (rde_log[i]) begin
        if (n == k) return int'(addr_log[i]);
        n++;
      end
    return -1;
  endfunction

  function automatic int back_to_back(int a, int b);
    int n = 0;
    for (int i = a + 1; i <= b; i++) if (rde_log[i] && rde_log[i-1]) n++;
    return n;
  endfunction

  function automatic int count_done(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (done_log[i]) n++;
    return n;
  endfunction

  function automatic int first_done(int a, int b);
    for (int i = a; i <= b; i++) if (done_log[i]) return i;
    return -1;
  endfunction

  function automatic int busy_lows(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (!busy_log[i]) n++;
    return n;
  endfunction

  function automatic int highs(int ch, int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (out_log[i][ch]) n++;
    return n;
  endfunction

  initial begin
    mem[0] = 48'h00000F_FF0000;
    mem[1] = 48'hA5A5A5_123456;
    mem[2] = 48'h800001_0F0F0F;
    mem[3] = 48'hC3C3C3_00FF00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dout", dout, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Single LED, both channels.
    start(3'd1, 2'b11);
    watch(270, -1, -1, 3'd0, 2'b00);
    chk("one_rd_en_first", rde_log[0], 1);
    chk("one_rd_addr_first", addr_log[0], 0);
    chk("one_busy_start", busy_log[0], 1);
    chk("one_before_rise", out_log[2], 0);
    chk("one_first_rise", out_log[3], 3);
    chk("one_ch0_t5_high", out_log[8][0], 1);
    chk("one_ch0_t6_low", out_log[9][0], 0);
    chk("one_ch0_t82_high", out_log[85][0], 1);
    chk("one_ch0_t83_low", out_log[86][0], 0);
    chk("one_ch1_t2_high", out_log[5][1], 1);
    chk("one_ch1_t3_low", out_log[6][1], 0);
    chk("one_ch1_t205_high", out_log[208][1], 1);
    chk("one_ch1_t206_low", out_log[209][1], 0);
    chk("one_wave_ch0", wave_err(0, 0, 269, 3, 1, 1'b1), 0);
    chk("one_wave_ch1", wave_err(1, 0, 269, 3, 1, 1'b1), 0);
    chk("one_reads", count_rd(0, 269), 1);
    chk("one_done_at", first_done(0, 269), 263);
    chk("one_done_count", count_done(0, 269), 1);
    chk("one_busy_before_done", busy_log[262], 1);
    chk("one_busy_at_done", busy_log[263], 0);

    // Three LEDs: continuous stream with prefetch.
    start(3'd3, 2'b11);
    watch(750, -1, -1, 3'd0, 2'b00);
    chk("three_reads", count_rd(0, 749), 3);
    chk("three_addr0", nth_addr(0, 749, 0), 0);
    chk("three_addr1", nth_addr(0, 749, 1), 1);
    chk("three_addr2", nth_addr(0, 749, 2), 2);
    chk("three_b2b", back_to_back(0, 749), 0);
    chk("three_wave_ch0", wave_err(0, 0, 749, 3, 3, 1'b1), 0);
    chk("three_wave_ch1", wave_err(1, 0, 749, 3, 3, 1'b1), 0);
    chk("three_done_at", first_done(0, 749), 743);

    // Count above LED_NUM clamps to 4.
    start(3'd7, 2'b11);
    watch(990, -1, -1, 3'd0, 2'b00);
    chk("clamp_reads", count_rd(0, 989), 4);
    chk("clamp_addr3", nth_addr(0, 989, 3), 3);
    chk("clamp_wave_ch0", wave_err(0, 0, 989, 3, 4, 1'b1), 0);
    chk("clamp_wave_ch1", wave_err(1, 0, 989, 3, 4, 1'b1), 0);
    chk("clamp_done_at", first_done(0, 989), 983);

    // Two requests during SEND: one queued frame sampling the new count/mask.
    start(3'd1, 2'b11);
    watch(775, 50, 60, 3'd2, 2'b10);
    chk("pend_done1_at", first_done(0, 774), 263);
    chk("pend_restart_rd", rde_log[263], 1);
    chk("pend_restart_addr", addr_log[263], 0);
    chk("pend_done2_at", first_done(264, 774), 766);
    chk("pend_done_count", count_done(0, 774), 2);
    chk("pend_reads", count_rd(0, 774), 3);
    chk("pend_busy_held", busy_lows(0, 765), 0);
    chk("pend_busy_end", busy_log[766], 0);
    chk("pend_f1_ch0", wave_err(0, 0, 262, 3, 1, 1'b1), 0);
    chk("pend_f2_ch0_off", wave_err(0, 263, 774, 266, 2, 1'b0), 0);
    chk("pend_f2_ch1", wave_err(1, 263, 774, 266, 2, 1'b1), 0);

    // Zero LEDs: straight to the latch gap.
    start(3'd0, 2'b11);
    watch(30, -1, -1, 3'd0, 2'b00);
    chk("zero_reads", count_rd(0, 29), 0);
    chk("zero_highs", highs(0, 0, 29) + highs(1, 0, 29), 0);
    chk("zero_done_at", first_done(0, 29), 20);
    chk("zero_busy_last", busy_log[19], 1);
    chk("zero_busy_end", busy_log[20], 0);

    // Channel mask: ch1 disabled.
    start(3'd1, 2'b01);
    watch(270, -1, -1, 3'd0, 2'b00);
    chk("mask_ch1_highs", highs(1, 0, 269), 0);
    chk("mask_wave_ch0", wave_err(0, 0, 269, 3, 1, 1'b1), 0);
    chk("mask_done_at", first_done(0, 269), 263);

    // Reset in the middle of a bit while both outputs are high.
    start(3'd2, 2'b11);
    watch(105, -1, -1, 3'd0, 2'b00);
    chk("rst_pre_high", out_log[104], 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    watch(600, -1, -1, 3'd0, 2'b00);
    chk("rst_no_done", count_done(0, 599), 0);
    chk("rst_no_reads", count_rd(0, 599), 0);
    chk("rst_quiet", highs(0, 0, 599) + highs(1, 0, 599), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
